// File: rtl/alu_arbiter_if.sv
// One requester channel: operation request plus its result handshake.
// Carries no state and adds no latency.
// Backpressure: req_ready and rsp_ready stall their own handshakes.
interface alu_arbiter_if #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [SEL_W-1:0] req_sel;
   logic             rsp_valid;
   logic             rsp_ready;

   // Requester side: issues operations and takes back results.
   modport master (
      output req_valid, req_a, req_b, req_sel, rsp_ready,
      input  req_ready, rsp_valid
   );

   // Arbiter side: accepts operations and presents results.
   modport slave (
      input  req_valid, req_a, req_b, req_sel, rsp_ready,
      output req_ready, rsp_valid
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Latency: operands registered on accept, result captured one cycle later.
// Backpressure: RESP holds (data stable, readies low) until the owner takes it.
module alu_arbiter #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   alu_arbiter_if.slave     req0,
   alu_arbiter_if.slave     req1,
   output logic [WIDTH:0]   rsp_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SEL_W-1:0] alu_sel,
   input  logic [WIDTH:0]   alu_out,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   logic [SEL_W-1:0] alu_sel_q;
   logic [WIDTH:0]   rsp_data_q;

   logic             gnt_vld;
   logic             gnt_id;
   logic             accept;
   logic             rsp_hs;

   // Grant selection: favoured requester wins a tie, otherwise the lone one.
   always_comb begin
      gnt_vld = req0.req_valid | req1.req_valid;
      gnt_id  = (req0.req_valid & req1.req_valid) ? prio_q : req1.req_valid;
      accept  = (state_q == IDLE) & gnt_vld;
      rsp_hs  = (state_q == RESP) & (owner_q ? req1.rsp_ready : req0.rsp_ready);
   end

   // State, priority and ownership registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
      end
   end

   // Next-state logic; priority flips away from the requester just served.
   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               state_d = EXEC;
               owner_d = gnt_id;
            end
         end
         EXEC: state_d = RESP;
         RESP: begin
            if (rsp_hs) begin
               state_d = IDLE;
               prio_d  = ~owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs; readies only in IDLE, so at most one is ever high.
   always_comb begin
      req0.req_ready = accept & ~gnt_id;
      req1.req_ready = accept &  gnt_id;
      req0.rsp_valid = (state_q == RESP) & ~owner_q;
      req1.rsp_valid = (state_q == RESP) &  owner_q;
      busy           = (state_q != IDLE);
   end

   // Datapath: operands latched only on accept, result only leaving EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_q    <= '0;
         alu_b_q    <= '0;
         alu_sel_q  <= '0;
         rsp_data_q <= '0;
      end else begin
         if (accept) begin
            alu_a_q   <= gnt_id ? req1.req_a   : req0.req_a;
            alu_b_q   <= gnt_id ? req1.req_b   : req0.req_b;
            alu_sel_q <= gnt_id ? req1.req_sel : req0.req_sel;
         end
         if (state_q == EXEC) begin
            rsp_data_q <= alu_out;
         end
      end
   end

   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_sel  = alu_sel_q;
   assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural add/xor ALU.
// Inputs change 1ns after the rising edge; outputs checked after settling.
// Backpressure exercised through rsp_ready holds and wrong-owner readies.
module tb_alu_arbiter;

   logic       clk;
   logic       rst_n;
   logic [8:0] rsp_data;
   logic [7:0] alu_a, alu_b;
   logic [2:0] alu_sel;
   logic [8:0] alu_out;
   logic       busy;

   int total;
   int bad;

   alu_arbiter_if #(.WIDTH(8), .SEL_W(3)) r0 ();
   alu_arbiter_if #(.WIDTH(8), .SEL_W(3)) r1 ();

   alu_arbiter #(.WIDTH(8), .SEL_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req0     (r0.slave),
      .req1     (r1.slave),
      .rsp_data (rsp_data),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_sel  (alu_sel),
      .alu_out  (alu_out),
      .busy     (busy)
   );

   // External ALU: add with carry, or xor.
   assign alu_out = (alu_sel == 3'b000) ? ({1'b0, alu_a} + {1'b0, alu_b}) :
                    (alu_sel == 3'b001) ? {1'b0, alu_a ^ alu_b} : 9'h000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      r0.req_valid = v; r0.req_a = a; r0.req_b = b; r0.req_sel = s;
   endtask

   task automatic set_req1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
      r1.req_valid = v; r1.req_a = a; r1.req_b = b; r1.req_sel = s;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      set_req0(1'b0, 8'h00, 8'h00, 3'b000);
      set_req1(1'b0, 8'h00, 8'h00, 3'b000);
      r0.rsp_ready = 1'b0;
      r1.rsp_ready = 1'b0;

      // Reset state.
      step();
      step();
      chk("rst_busy", busy, 0);
      chk("rst_rsp0v", r0.rsp_valid, 0);
      chk("rst_rsp1v", r1.rsp_valid, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_rsp_data", rsp_data, 0);
      #2 rst_n = 1'b1;
      step();
      chk("idle_rdy0", r0.req_ready, 0);
      chk("idle_rdy1", r1.req_ready, 0);

      // Single request: FF + 01 carries into bit 8.
      set_req0(1'b1, 8'hFF, 8'h01, 3'b000);
      r0.rsp_ready = 1'b1;
      #1;
      chk("single_rdy0", r0.req_ready, 1);
      chk("single_rdy1", r1.req_ready, 0);
      step();
      r0.req_valid = 1'b0;
      #1;
      chk("single_exec_busy", busy, 1);
      chk("single_alu_a", alu_a, 8'hFF);
      chk("single_alu_b", alu_b, 8'h01);
      chk("single_exec_rsp0v", r0.rsp_valid, 0);
      chk("single_exec_rdy0", r0.req_ready, 0);
      step();
      chk("single_rsp0v", r0.rsp_valid, 1);
      chk("single_data", rsp_data, 9'h100);
      step();
      chk("single_done_busy", busy, 0);
      chk("single_done_rsp0v", r0.rsp_valid, 0);

      // Reset while in RESP discards the response.
      set_req1(1'b1, 8'h05, 8'h06, 3'b000);
      r1.rsp_ready = 1'b0;
      #1;
      chk("pre_rst_rdy1", r1.req_ready, 1);
      step();
      r1.req_valid = 1'b0;
      step();
      chk("pre_rst_rsp1v", r1.rsp_valid, 1);
      chk("pre_rst_data", rsp_data, 9'h00B);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_rsp0v", r0.rsp_valid, 0);
      chk("midrst_rsp1v", r1.rsp_valid, 0);
      chk("midrst_alu_a", alu_a, 0);
      chk("midrst_data", rsp_data, 0);
      #1 rst_n = 1'b1;

      // Lone req1 after reset, then response backpressure for 5 cycles.
      set_req1(1'b1, 8'h10, 8'h20, 3'b001);
      #1;
      chk("post_rst_rdy1", r1.req_ready, 1);
      chk("post_rst_rdy0", r0.req_ready, 0);
      step();
      r1.req_valid = 1'b0;
      set_req0(1'b1, 8'h0F, 8'hF0, 3'b000);
      r0.rsp_ready = 1'b1;
      #1;
      chk("bp_exec_rdy0", r0.req_ready, 0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp1v", r1.rsp_valid, 1);
         chk("bp_rsp0v", r0.rsp_valid, 0);
         chk("bp_data", rsp_data, 9'h030);
         chk("bp_rdy0", r0.req_ready, 0);
         chk("bp_busy", busy, 1);
         step();
      end
      r1.rsp_ready = 1'b1;
      r0.rsp_ready = 1'b0;
      step();
      chk("bp_done_busy", busy, 0);
      chk("bp_done_rsp1v", r1.rsp_valid, 0);
      chk("bp_next_rdy0", r0.req_ready, 1);

      // Operand change after accept, then wrong-owner rsp_ready.
      step();
      r0.req_a = 8'h00;
      step();
      chk("opchg_rsp0v", r0.rsp_valid, 1);
      chk("opchg_data", rsp_data, 9'h0FF);
      step();
      step();
      chk("wrong_own_busy", busy, 1);
      chk("wrong_own_rsp0v", r0.rsp_valid, 1);
      chk("wrong_own_rsp1v", r1.rsp_valid, 0);
      chk("wrong_own_data", rsp_data, 9'h0FF);
      r0.req_valid = 1'b0;
      r0.rsp_ready = 1'b1;
      step();
      chk("wrong_own_done_busy", busy, 0);
      chk("wrong_own_done_rsp0v", r0.rsp_valid, 0);

      // Contention from reset: strict alternation starting with requester 0.
      #2 rst_n = 1'b0;
      set_req0(1'b1, 8'h03, 8'h04, 3'b000);
      set_req1(1'b1, 8'hAA, 8'h0F, 3'b001);
      r0.rsp_ready = 1'b1;
      r1.rsp_ready = 1'b1;
      #2 rst_n = 1'b1;
      #1;
      for (int i = 0; i < 6; i++) begin
         logic own;
         own = i[0];
         chk("cont_idle_busy", busy, 0);
         chk("cont_rdy0", r0.req_ready, own == 1'b0);
         chk("cont_rdy1", r1.req_ready, own == 1'b1);
         step();
         step();
         chk("cont_rsp0v", r0.rsp_valid, own == 1'b0);
         chk("cont_rsp1v", r1.rsp_valid, own == 1'b1);
         chk("cont_data", rsp_data, own ? 9'h0A5 : 9'h007);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin controller that shares one combinational 8-bit ALU between two requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block registers the winning operation onto the ALU inputs, captures the 9-bit ALU result one cycle later, and returns it to the owning requester with a second valid/ready handshake. It sits between the requester logic and the ALU instance; the ALU itself is external and purely combinational.

## Interface
- WIDTH, 8, operand width; result width is WIDTH+1 (carry/borrow bit in MSB)
- SEL_W, 3, opcode width passed through to ALU unchanged
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  request accepted when valid&ready at rising edge
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands, sampled only at accept edge
- req0_sel / req1_sel  in  SEL_W  opcode, sampled only at accept edge
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_data  out  WIDTH+1  shared result bus; meaningful only while a rspX_valid is high
- alu_a, alu_b  out  WIDTH  registered ALU operands
- alu_sel  out  SEL_W  registered ALU opcode
- alu_out  in  WIDTH+1  combinational ALU result
- busy  out  1  high whenever state is not IDLE

## Operation
- States: IDLE, EXEC, RESP.
- Priority pointer `prio` (1 bit) names the favoured requester; reset value 0.
- Grant (combinational, IDLE only): if both valid, grant = prio; if one valid, grant = that one; none valid → no grant.
- reqX_ready = (state==IDLE) && grant==X. At most one ready high per cycle; readies are never high outside IDLE.
- IDLE → EXEC on accept: alu_a/alu_b/alu_sel ← granted operands; owner ← grant.
- EXEC → RESP unconditionally: rsp_data ← alu_out (all WIDTH+1 bits, no modification).
- RESP: rspX_valid = (owner==X). On rsp handshake (rspX_valid && rspX_ready): state → IDLE, prio ← ~owner.
- RESP holds indefinitely while rsp_ready is low; rsp_data, alu_a/b/sel stay stable.
- alu_a/b/sel hold their last value outside accept edges (no return to zero).
- Requester dropping valid before ready: legal, no side effect. rsp_ready of the non-owner is ignored.
- Reset values: state IDLE, prio 0, owner 0, alu_a/alu_b/alu_sel 0, rsp_data 0, all rspX_valid 0, busy 0. Readies follow the grant rule once out of reset.
- Reset asserted mid-operation: in-flight operation is discarded, no response is issued, and prio returns to 0.

## Timing
- Edge T: request accepted (valid&ready high). alu_* update after T.
- Edge T+1: result captured; rspX_valid high from T+1.
- Earliest rsp handshake at edge T+2 (rsp_ready already high) → IDLE after T+2; next accept no earlier than T+3.
- Peak throughput: one operation per 3 cycles. Request-to-result latency: 1 cycle after accept.
- No combinational path from reqX_valid to rsp outputs; readies depend combinationally on req valids, state, prio.
- Both requesters continuously valid: strict alternation 0,1,0,1… starting with requester 0 after reset.

## Test plan
ALU model on the bench: alu_out = {1'b0,alu_a} + alu_b for sel=000 and {1'b0,alu_a ^ alu_b} for sel=001.
- Reset: rst_n low mid-cycle with state RESP → busy, rsp0_valid, and rsp1_valid drop immediately; alu_a=0 and rsp_data=0; after release, a lone req1 is granted.
- Single request: req0 a=8'hFF, b=8'h01, sel=000, rsp0_ready=1 → req0_ready at accept; rsp0_valid one cycle later with rsp_data=9'h100; IDLE after the handshake.
- Contention: both valid from reset (req0 a=3,b=4,sel=000; req1 a=8'hAA,b=8'h0F,sel=001) → req0 served first (9'h007), then req1 (9'h0A5), and grants alternate for 6 operations.
- Response backpressure: rsp1_ready low for 5 cycles → rsp1_valid and rsp_data stable; req0_ready stays low throughout; completion on the first cycle rsp1_ready is high.
- Wrong-owner ready: owner=0, rsp1_ready=1, rsp0_ready=0 → no completion; state remains RESP.
- Operand change after accept: alter req0_a the cycle after accept → rsp_data reflects the operands sampled at the accept edge.
